// File: rtl/dma_reg_pkg.sv
// dma_reg_pkg
// Shared constants for the DMA configuration/status register bank:
//   - default base address and the size of the mapped window
//   - register byte offsets and register indices
//   - reset values, writable-bit masks and write-1-to-clear masks
// Ports: none (package).

package dma_reg_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0400;
    localparam int          NUM_REGS          = 10;
    // Ten word registers occupy byte offsets 0x00..0x27.
    localparam logic [31:0] REG_SPAN          = 32'h0000_0028;

    localparam logic [31:0] INTR_OFS            = 32'h00;
    localparam logic [31:0] CTRL_OFS            = 32'h04;
    localparam logic [31:0] IO_ADDR_OFS         = 32'h08;
    localparam logic [31:0] MEM_ADDR_OFS        = 32'h0C;
    localparam logic [31:0] EXTRA_INFO_OFS      = 32'h10;
    localparam logic [31:0] STATUS_OFS          = 32'h14;
    localparam logic [31:0] TRANSFER_COUNT_OFS  = 32'h18;
    localparam logic [31:0] DESCRIPTOR_ADDR_OFS = 32'h1C;
    localparam logic [31:0] ERROR_STATUS_OFS    = 32'h20;
    localparam logic [31:0] CONFIG_OFS          = 32'h24;

    // Register index = byte offset / 4.
    typedef enum logic [3:0] {
        IDX_INTR            = 4'd0,
        IDX_CTRL            = 4'd1,
        IDX_IO_ADDR         = 4'd2,
        IDX_MEM_ADDR        = 4'd3,
        IDX_EXTRA_INFO      = 4'd4,
        IDX_STATUS          = 4'd5,
        IDX_TRANSFER_COUNT  = 4'd6,
        IDX_DESCRIPTOR_ADDR = 4'd7,
        IDX_ERROR_STATUS    = 4'd8,
        IDX_CONFIG          = 4'd9
    } reg_idx_e;

    localparam logic [31:0] CONFIG_RESET = 32'h0000_0001;

    // Bits a bus write stores directly. CTRL[0] (start) is a strobe and is
    // never stored, so it is excluded here.
    localparam logic [31:0] CTRL_RW_MASK   = 32'h0000_0006;
    localparam logic [31:0] TCOUNT_RW_MASK = 32'h0000_FFFF;
    localparam logic [31:0] CONFIG_RW_MASK = 32'h0000_01FF;

    // Bits cleared by writing 1.
    localparam logic [31:0] STATUS_W1C_MASK = 32'h0000_0001;
    localparam logic [31:0] ERROR_W1C_MASK  = 32'h0000_0003;

    function automatic logic [31:0] reset_value(input logic [3:0] idx);
        logic [31:0] v;
        v = '0;
        if (idx == IDX_CONFIG) v = CONFIG_RESET;
        return v;
    endfunction

    function automatic logic [31:0] rw_mask(input logic [3:0] idx);
        logic [31:0] m;
        case (idx)
            IDX_INTR,
            IDX_IO_ADDR,
            IDX_MEM_ADDR,
            IDX_EXTRA_INFO,
            IDX_DESCRIPTOR_ADDR: m = 32'hFFFF_FFFF;
            IDX_CTRL:            m = CTRL_RW_MASK;
            IDX_TRANSFER_COUNT:  m = TCOUNT_RW_MASK;
            IDX_CONFIG:          m = CONFIG_RW_MASK;
            default:             m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] w1c_mask(input logic [3:0] idx);
        logic [31:0] m;
        case (idx)
            IDX_STATUS:       m = STATUS_W1C_MASK;
            IDX_ERROR_STATUS: m = ERROR_W1C_MASK;
            default:          m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dma_modport_if.sv
// dma_modport_if
// Single-beat register access bus.
//   addr  : byte address of the access
//   wr_en : 1 = write, 0 = read (qualified by valid)
//   valid : one access per cycle in which it is high
//   wdata : write data
//   rdata : read data, loaded one cycle after a read request
// Handshake: there is no ready; every cycle with valid=1 is accepted at
// the next rising clk edge. rdata holds its value until the next read.
// Modports: master drives the request, slave returns rdata.

interface dma_modport_if;
    logic [31:0] addr;
    logic        wr_en;
    logic        valid;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wr_en,
        output valid,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  valid,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/dma_reg_decode.sv
// dma_reg_decode
// Combinational address decode for the DMA register bank.
// Ports:
//   addr     (in,  32) : byte address of the access
//   sel      (out, 10) : one-hot register select, all zero when unmapped
//   unmapped (out, 1)  : address outside the window or not word aligned

module dma_reg_decode
    import dma_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic [31:0]         addr,
    output logic [NUM_REGS-1:0] sel,
    output logic                unmapped
);

    logic [31:0] offset;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    assign offset = addr - BASE_ADDR;

    always_comb begin
        sel      = '0;
        unmapped = 1'b1;
        if (addr[1:0] == 2'b00 && offset < REG_SPAN) begin
            unmapped         = 1'b0;
            sel[offset[5:2]] = 1'b1;
        end
    end

endmodule

// File: rtl/dma_modport.sv
// dma_modport
// Configuration/status register bank for a DMA engine: ten 32-bit
// registers with RW, RO and W1C fields behind a single-beat bus.
// Ports:
//   clk   (in)          : single clock, rising edge
//   reset (in)          : asynchronous active-low reset
//   bus   (slave mport) : addr / wr_en / valid / wdata in, rdata out
// Reads return data one cycle after the request; unmapped reads return 0.
// Unmapped writes and reads are recorded in ERROR_STATUS[0] / [1].

module dma_modport
    import dma_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic         clk,
    input  logic         reset,
    dma_modport_if.slave bus
);

    logic [NUM_REGS-1:0] sel;
    logic                unmapped;
    logic                wr_acc;
    logic                rd_acc;
    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic [31:0]         rd_mux;
    logic [31:0]         rdata_q;

    dma_reg_decode #(
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .addr     (bus.addr),
        .sel      (sel),
        .unmapped (unmapped)
    );

    assign wr_acc = bus.valid &  bus.wr_en;
    assign rd_acc = bus.valid & ~bus.wr_en;

    // Next-state for every register: bus write first, then hardware sets,
    // so a hardware set overrides a W1C clear of the same bit.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_acc && sel[i]) begin
                regs_d[i] = (regs_q[i] & ~rw_mask(4'(i))) |
                            (bus.wdata & rw_mask(4'(i)));
                regs_d[i] = regs_d[i] & ~(bus.wdata & w1c_mask(4'(i)));
            end
        end

        // CTRL.start is a one-cycle strobe derived from the write itself;
        // it is never stored (reads 0) and is recorded as STATUS.start_seen.
        if (wr_acc && sel[IDX_CTRL] && bus.wdata[0])
            regs_d[IDX_STATUS][0] = 1'b1;

        if (wr_acc && unmapped)
            regs_d[IDX_ERROR_STATUS][0] = 1'b1;
        if (rd_acc && unmapped)
            regs_d[IDX_ERROR_STATUS][1] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= reset_value(4'(i));
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= regs_d[i];
        end
    end

    // One-hot select makes the read mux a plain OR; sel is all zero for
    // unmapped addresses, which yields the required 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (sel[i]) rd_mux = rd_mux | regs_q[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= unmapped ? 32'h0 : rd_mux;
        end
    end

    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dma_modport.sv
// tb_dma_modport
// Self-checking bench for dma_modport: directed register tests plus random
// traffic, compared every cycle against a behavioural register model.

module tb_dma_modport;

    localparam logic [31:0] BASE = 32'h0000_0400;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dma_modport_if bus ();

    dma_modport #(
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m [10];
    logic [31:0] exp_rdata;

    function automatic void model_reset();
        for (int i = 0; i < 10; i++) m[i] = 32'h0;
        m[9]      = 32'h0000_0001;
        exp_rdata = 32'h0;
    endfunction

    // Effect of one accepted access, written register by register.
    function automatic void model_apply(input logic we, input logic [31:0] a,
                                        input logic [31:0] d);
        logic [31:0] ofs;
        int          k;
        ofs = a - BASE;
        if (a[1:0] != 2'b00 || ofs >= 32'd40) begin
            if (we) m[8] = m[8] | 32'h1;
            else begin
                m[8]      = m[8] | 32'h2;
                exp_rdata = 32'h0;
            end
            return;
        end
        k = int'(ofs / 4);
        if (!we) begin
            exp_rdata = m[k];
            return;
        end
        case (k)
            0, 2, 3, 4, 7: m[k] = d;
            1: begin
                m[1] = d & 32'h0000_0006;
                if (d % 2 == 1) m[5] = 32'h1;
            end
            5: if (d % 2 == 1) m[5] = 32'h0;
            6: m[6] = d % 32'h0001_0000;
            8: m[8] = m[8] & ~(d & 32'h3);
            9: m[9] = d & 32'h0000_01FF;
            default: ;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    int          n_checks;
    int          n_pass;
    logic        lit_on;
    logic [31:0] lit_val;
    string       lit_name;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        forever begin
            @(negedge clk);
            n_checks++;
            if (bus.rdata === exp_rdata) n_pass++;
            else $display("FAIL model_rdata t=%0t: got %h expected %h",
                          $time, bus.rdata, exp_rdata);
            if (lit_on) begin
                n_checks++;
                if (bus.rdata === lit_val) n_pass++;
                else $display("FAIL %s: got %h expected %h",
                              lit_name, bus.rdata, lit_val);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] d);
        bus.valid = 1'b1;
        bus.wr_en = we;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        model_apply(we, a, d);
    endtask

    task automatic idle();
        bus.valid = 1'b0;
        bus.wr_en = 1'($urandom_range(0, 1));
        bus.addr  = BASE + 32'($urandom_range(0, 11) * 4);
        bus.wdata = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic lit_expect(input string name, input logic [31:0] v);
        lit_name = name;
        lit_val  = v;
        lit_on   = 1'b1;
        @(negedge clk);
        #1;
        lit_on   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
        access(1'b1, BASE + ofs, d);
    endtask

    task automatic rd_check(input string name, input logic [31:0] ofs,
                            input logic [31:0] v);
        access(1'b0, BASE + ofs, 32'h0);
        lit_expect(name, v);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] reset_vals [10];
    logic [31:0] a;

    initial begin
        lit_on    = 1'b0;
        lit_val   = '0;
        lit_name  = "";
        bus.valid = 1'b0;
        bus.wr_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        rst_n     = 1'b0;
        model_reset();

        // rdata is 0 while reset is held
        lit_expect("rdata_in_reset", 32'h0);
        rst_n = 1'b1;

        // reset values of all ten registers
        for (int i = 0; i < 10; i++) reset_vals[i] = 32'h0;
        reset_vals[9] = 32'h0000_0001;
        for (int i = 0; i < 10; i++)
            rd_check($sformatf("reset_reg_%0d", i), 32'(i * 4), reset_vals[i]);

        // RW round trip
        wr(32'h08, 32'hA5A5_5A5A);
        wr(32'h0C, 32'hA5A5_5A5A);
        wr(32'h1C, 32'hA5A5_5A5A);
        wr(32'h10, 32'hA5A5_5A5A);
        rd_check("rw_io_addr",    32'h08, 32'hA5A5_5A5A);
        rd_check("rw_mem_addr",   32'h0C, 32'hA5A5_5A5A);
        rd_check("rw_desc_addr",  32'h1C, 32'hA5A5_5A5A);
        rd_check("rw_extra_info", 32'h10, 32'hA5A5_5A5A);

        // field masking
        wr(32'h18, 32'hFFFF_FFFF);
        rd_check("mask_tcount", 32'h18, 32'h0000_FFFF);
        wr(32'h24, 32'hFFFF_FFFF);
        rd_check("mask_config", 32'h24, 32'h0000_01FF);
        wr(32'h04, 32'hFFFF_FFFF);
        rd_check("mask_ctrl", 32'h04, 32'h0000_0006);

        // start strobe and W1C
        wr(32'h14, 32'h1);
        rd_check("status_cleared_pre", 32'h14, 32'h0);
        wr(32'h04, 32'h1);
        rd_check("status_start_seen", 32'h14, 32'h1);
        wr(32'h14, 32'h0);
        rd_check("status_w0_keeps", 32'h14, 32'h1);
        wr(32'h14, 32'h1);
        rd_check("status_w1_clears", 32'h14, 32'h0);

        // unmapped accesses
        wr(32'h28, 32'h1234);
        rd_check("unmapped_wr_no_change", 32'h08, 32'hA5A5_5A5A);
        rd_check("err_after_unmapped_wr", 32'h20, 32'h1);
        access(1'b0, BASE + 32'h02, 32'h0);
        lit_expect("unmapped_rd_data", 32'h0);
        rd_check("err_after_unmapped_rd", 32'h20, 32'h3);
        wr(32'h20, 32'h3);
        rd_check("err_w1c_clear", 32'h20, 32'h0);

        // asynchronous reset during traffic, with an access in flight
        wr(32'h00, 32'hFFFF_0001);
        rd_check("intr_written", 32'h00, 32'hFFFF_0001);
        @(posedge clk);
        #2;
        bus.valid = 1'b1;
        bus.wr_en = 1'b1;
        bus.addr  = BASE;
        bus.wdata = 32'hDEAD_BEEF;
        #1;
        rst_n     = 1'b0;
        model_reset();
        #1;
        bus.valid = 1'b0;
        lit_expect("rdata_async_reset", 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        rd_check("intr_after_reset",   32'h00, 32'h0);
        rd_check("config_after_reset", 32'h24, 32'h0000_0001);
        rd_check("err_after_reset",    32'h20, 32'h0);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel < 14)       a = BASE + 32'($urandom_range(0, 9) * 4);
            else if (sel == 14) a = BASE + 32'h28;
            else if (sel == 15) a = BASE + 32'h2C;
            else if (sel == 16) a = BASE + 32'($urandom_range(0, 9) * 4)
                                    + 32'($urandom_range(1, 3));
            else if (sel == 17) a = BASE - 32'h4;
            else if (sel == 18) a = 32'($urandom);
            else                a = BASE + 32'h20;
            if ($urandom_range(0, 4) == 0) idle();
            access(1'($urandom_range(0, 1)), a,
                   ($urandom_range(0, 1) == 1) ? $urandom
                                                : 32'($urandom_range(0, 7)));
        end

        // final sweep of every register against the model
        for (int i = 0; i < 10; i++) access(1'b0, BASE + 32'(i * 4), 32'h0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
